// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the multicore data-memory arbiter.
package data_mem_arbiter_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  localparam int MAX_CORES = 16;

  // Core-ID field width; a single-bit field is kept even for degenerate counts.
  function automatic int id_width(input int n_cores);
    return (n_cores > 1) ? $clog2(n_cores) : 1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_select.sv
// Combinational priority picker: first asserted request at or after i_start, wrapping.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  int w_pos;

  always_comb begin
    // NOTE: every output gets a default first so no path through the loop infers a latch.
    o_gnt   = '0;
    o_idx   = '0;
    o_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(i_start) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!o_found && i_req[w_pos[IW-1:0]]) begin
        o_found               = 1'b1;
        o_gnt[w_pos[IW-1:0]]  = 1'b1;
        o_idx                 = w_pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data-memory arbiter for N_CORES cores with fixed-latency read return.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int        N_CORES   = 4,
  parameter int        REG_WIDTH = 12,
  parameter int        MEM_LAT   = 1,
  parameter arb_mode_t MODE      = ARB_RR
) (
  input  logic                               clk,
  input  logic                               rstN,
  input  logic [N_CORES-1:0]                 coreReq,
  input  logic [N_CORES-1:0]                 coreWrEn,
  input  logic [N_CORES-1:0][REG_WIDTH-1:0]  coreAddr,
  input  logic [N_CORES-1:0][REG_WIDTH-1:0]  coreWrData,
  output logic [N_CORES-1:0]                 coreGnt,
  output logic [REG_WIDTH-1:0]               coreRdData,
  output logic [N_CORES-1:0]                 coreRdValid,
  output logic [REG_WIDTH-1:0]               dataMemAddr,
  output logic [REG_WIDTH-1:0]               DataMemIn,
  output logic                               DataMemWrEn,
  input  logic [REG_WIDTH-1:0]               DataMemOut
);

  localparam int IW = id_width(N_CORES);

  logic [IW-1:0]      r_rr_ptr;
  logic [MEM_LAT-1:0] r_pipe_vld;
  logic [IW-1:0]      r_pipe_id [MEM_LAT];

  logic [IW-1:0]      w_start;
  logic [N_CORES-1:0] w_sel_gnt;
  logic [IW-1:0]      w_idx;
  logic               w_found;
  logic               w_grant;
  logic               w_rd_push;
  logic               w_exit_vld;
  logic [IW-1:0]      w_exit_id;

  assign w_start = (MODE == ARB_RR) ? r_rr_ptr : '0;

  rr_select #(.N(N_CORES), .IW(IW)) u_select (
    .i_req   (coreReq),
    .i_start (w_start),
    .o_gnt   (w_sel_gnt),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  // Masked by rstN so nothing is granted (or accepted) while reset is held.
  assign w_grant    = w_found & rstN;
  assign w_rd_push  = w_grant & ~coreWrEn[w_idx];
  assign w_exit_vld = r_pipe_vld[MEM_LAT-1];
  assign w_exit_id  = r_pipe_id[MEM_LAT-1];

  always_comb begin
    coreGnt     = '0;
    dataMemAddr = '0;
    DataMemIn   = '0;
    DataMemWrEn = 1'b0;
    if (w_grant) begin
      coreGnt     = w_sel_gnt;
      dataMemAddr = coreAddr[w_idx];
      DataMemIn   = coreWrData[w_idx];
      DataMemWrEn = coreWrEn[w_idx];
    end
  end

  always_comb begin
    coreRdValid = '0;
    coreRdData  = '0;
    if (w_exit_vld) begin
      coreRdValid[w_exit_id] = 1'b1;
      coreRdData             = DataMemOut;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rr_ptr   <= '0;
      r_pipe_vld <= '0;
    end else begin
      // NOTE: non-blocking so each pipeline stage samples its predecessor's pre-edge value.
      if (MODE == ARB_RR && w_grant)
        r_rr_ptr <= (w_idx == IW'(N_CORES - 1)) ? '0 : w_idx + IW'(1);
      r_pipe_vld[0] <= w_rd_push;
      for (int s = 1; s < MEM_LAT; s++) r_pipe_vld[s] <= r_pipe_vld[s-1];
    end
  end

  // NOTE: the ID payload is left unreset; the valid bits alone decide whether it is used.
  always_ff @(posedge clk) begin
    r_pipe_id[0] <= w_idx;
    for (int s = 1; s < MEM_LAT; s++) r_pipe_id[s] <= r_pipe_id[s-1];
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares one single-port data memory among N_CORES processor cores in the multicore build.
- Each cycle, grants at most one core's read or write request to the memory.
- Returns read data to the requesting core after a fixed memory latency.
- Parametrised in core count, data/address width, memory read latency and arbitration mode (round-robin or fixed priority).

Parameters:
- N_CORES, 4, number of requesting cores (2..16)
- REG_WIDTH, 12, data word width and data-memory address width
- MEM_LAT, 1, data-memory read latency in cycles (1..4)
- MODE, ARB_RR, arbitration mode: ARB_RR round-robin, ARB_FIXED core 0 highest priority

Ports:
- clk  in  1  clock
- rstN  in  1  asynchronous active-low reset
- coreReq  in  N_CORES  per-core request, held until granted
- coreWrEn  in  N_CORES  per-core write (1) / read (0) qualifier
- coreAddr  in  N_CORES x REG_WIDTH  per-core address, packed [N_CORES-1:0][REG_WIDTH-1:0]
- coreWrData  in  N_CORES x REG_WIDTH  per-core write data
- coreGnt  out  N_CORES  one-hot grant; request accepted this cycle
- coreRdData  out  REG_WIDTH  read data, shared bus
- coreRdValid  out  N_CORES  one-hot; coreRdData belongs to this core this cycle
- dataMemAddr  out  REG_WIDTH  memory address
- DataMemIn  out  REG_WIDTH  memory write data
- DataMemWrEn  out  1  memory write enable
- DataMemOut  in  REG_WIDTH  memory read data, valid MEM_LAT cycles after address

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on rstN; all state clears immediately on rstN low.
- Reset state:
  - rrPtr=0; latency pipeline empty.
  - coreGnt=0, coreRdValid=0, DataMemWrEn=0, dataMemAddr=0, DataMemIn=0, coreRdData=0.
- Arbitration is combinational within the cycle. Grant goes to the first asserted coreReq:
  - ARB_RR: scan from index rrPtr upward, wrapping N_CORES-1 -> 0.
  - ARB_FIXED: scan from index 0.
- Granted core i:
  - coreGnt[i]=1.
  - dataMemAddr=coreAddr[i], DataMemIn=coreWrData[i], DataMemWrEn=coreWrEn[i].
  - Accepted at the rising edge.
- No request: coreGnt=0, DataMemWrEn=0, dataMemAddr=0, DataMemIn=0.
- rrPtr update, ARB_RR only: on a grant to i, rrPtr <= (i+1) mod N_CORES. No grant leaves rrPtr unchanged. ARB_FIXED never updates rrPtr.
- Throughput: one access per cycle. Back-to-back grants are allowed, including to the same core when it is the only requester.
- Read return:
  - Each granted read pushes {valid, coreId} into a MEM_LAT-deep shift pipeline.
  - When the entry exits, coreRdValid[coreId]=1 for one cycle and coreRdData=DataMemOut.
  - Writes push valid=0.
  - coreRdData is 0 when no valid entry exits.
- Ordering: reads return in grant order. Exactly one coreRdValid bit is set at most per cycle.
- A core must not deassert or change coreReq/coreAddr/coreWrEn/coreWrData before its coreGnt. Behaviour on violation is unspecified.
- A core may issue a new request in the cycle its previous read data returns.
- Reset mid-operation: pipeline flushed, in-flight reads dropped with no coreRdValid, rrPtr returns to 0.
- Boundary conditions:
  - All N_CORES requesting: ARB_RR serves each exactly once in N_CORES consecutive cycles.
  - rrPtr wrap from N_CORES-1 to 0 must be covered.
- Width: the core ID field is $clog2(N_CORES) bits, minimum 1.

Decomposition:
- Package details:
  - arb_mode_t enum {ARB_RR, ARB_FIXED}.
  - MAX_CORES=16 constant.
- Sub-module rr_select:
  - Parametrised combinational priority picker over N_CORES request bits with a start index.
  - Outputs one-hot grant, binary index and a found flag.
  - Used for both modes (ARB_FIXED passes start=0).

Test Plan:
1. Reset with coreReq=4'b1111 held, rstN=0 -> coreGnt=0, DataMemWrEn=0, coreRdValid=0. After release, first grant is core0 in both modes.
2. ARB_RR, N_CORES=4, all four requesting reads at addresses 0x010..0x013, each core dropping its request after its grant -> coreGnt sequence 0001,0010,0100,1000. coreRdValid follows one cycle later (MEM_LAT=1) with memory contents at 0x010..0x013.
3. ARB_FIXED, core0 requesting continuously, core3 requesting -> core3 never granted while core0 requests. Core3 is granted the cycle after core0 drops.
4. Write then read: core2 writes 0xABC to addr 0x005, then core1 reads 0x005 -> DataMemWrEn=1 for one cycle, no coreRdValid for the write. coreRdValid=4'b0010 with coreRdData=0xABC.
5. MEM_LAT=3, alternate core0 and core1 reads on consecutive cycles -> coreRdValid pattern 0001,0010,0001 starting 3 cycles after first grant, data in order.
6. rstN pulsed low while two reads are in flight (MEM_LAT=3) -> no coreRdValid after reset, rrPtr=0, next grant follows from core0.
